// File: rtl/if_fetch_buf.sv
// if_fetch_buf: fetch PC + credit-gated imem requests (req/addr/gnt/rvalid/rdata) feeding an in-order FIFO to decode (inst_valid/ready/inst/pc), flushed by redirect
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
  logic [31:0] fetch_pc, resp_pc, last_inst, last_pc, target;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [CW-1:0] outstanding, discard, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic grant, push, pop;
  assign target = {redirect_pc_in[31:2], 2'b00};
  assign imem_req_out = !rst && !redirect_valid_in && ({1'b0, outstanding} + {1'b0, count} < LIMIT);
  assign imem_addr_out = fetch_pc;
  assign grant = imem_req_out && imem_gnt_in;
  assign push = imem_rvalid_in && discard == '0 && !redirect_valid_in;
  assign inst_valid_out = count != '0;
  assign pop = inst_valid_out && inst_ready_in && !redirect_valid_in;
  assign inst_out = inst_valid_out ? inst_mem[rd_ptr] : last_inst;
  assign pc_out = inst_valid_out ? pc_mem[rd_ptr] : last_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last_inst <= '0;
      last_pc <= '0;
    end else begin
      last_inst <= inst_out;
      last_pc <= pc_out;
      if (redirect_valid_in) begin
        fetch_pc <= target;
        resp_pc <= target;
        outstanding <= outstanding - CW'(imem_rvalid_in);
        discard <= outstanding - CW'(imem_rvalid_in);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        fetch_pc <= grant ? fetch_pc + 32'd4 : fetch_pc;
        resp_pc <= push ? resp_pc + 32'd4 : resp_pc;
        outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_in);
        discard <= (imem_rvalid_in && discard != '0) ? discard - 1'b1 : discard;
        count <= count + CW'(push) - CW'(pop);
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata_in;
      pc_mem[wr_ptr] <= resp_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid_in && outstanding == '0));
      assert (!(imem_gnt_in && !imem_req_out && !redirect_valid_in));
    end
  end
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: random/directed stimulus against an epoch-tagged request/stream reference model
module tb_if_fetch_buf;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 0, rst = 1;
  logic redirect_valid_in = 0, imem_gnt_in = 0, imem_rvalid_in = 0, inst_ready_in = 0;
  logic [31:0] redirect_pc_in = 0, imem_rdata_in = 0;
  logic imem_req_out, inst_valid_out;
  logic [31:0] imem_addr_out, inst_out, pc_out;
  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  req_t pend[$];
  logic [31:0] dq[$];
  logic [31:0] mfetch = RESET_PC, last_pc = 0, last_inst = 0;
  int epoch = 0, cyc = 0, tests = 0, fails = 0, lat_min = 1, lat_max = 1;
  if_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out), .imem_gnt_in(imem_gnt_in),
    .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
    .inst_out(inst_out), .pc_out(pc_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req_out}, 0);
    chk({tag, "_addr"}, imem_addr_out, RESET_PC);
    chk({tag, "_valid"}, {31'd0, inst_valid_out}, 0);
    chk({tag, "_inst"}, inst_out, 0);
    chk({tag, "_pc"}, pc_out, 0);
  endtask
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input int gp, input int rp);
    logic exp_req, rv, fire, pop;
    req_t r;
    redirect_valid_in = redir;
    redirect_pc_in = rpc;
    inst_ready_in = rdy;
    rv = pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rp;
    imem_rvalid_in = rv;
    imem_rdata_in = rv ? memword(pend[0].addr) : 32'h0;
    #1;
    exp_req = !redir && (pend.size() + dq.size() < DEPTH);
    chk("req", {31'd0, imem_req_out}, {31'd0, exp_req});
    chk("addr", imem_addr_out, mfetch);
    imem_gnt_in = (imem_req_out || redir) && $urandom_range(99) < gp;
    #1;
    chk("valid", {31'd0, inst_valid_out}, {31'd0, dq.size() > 0});
    chk("pc", pc_out, dq.size() > 0 ? dq[0] : last_pc);
    chk("inst", inst_out, dq.size() > 0 ? memword(dq[0]) : last_inst);
    @(posedge clk);
    fire = exp_req && imem_gnt_in;
    pop = dq.size() > 0 && rdy;
    if (dq.size() > 0) begin
      last_pc = dq[0];
      last_inst = memword(dq[0]);
    end
    if (pop) void'(dq.pop_front());
    if (rv) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redir) dq.push_back(r.addr);
    end
    if (fire) begin
      pend.push_back('{mfetch, epoch, cyc + $urandom_range(lat_max, lat_min)});
      mfetch = mfetch + 32'd4;
    end
    if (redir) begin
      epoch++;
      dq.delete();
      mfetch = {rpc[31:2], 2'b00};
    end
    cyc++;
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    // stream with 1-cycle memory, always granting, decode always ready
    lat_min = 1; lat_max = 1;
    repeat (20) step(0, 0, 1, 100, 100);
    // decode stalled: credit limit must stop requests, then drain
    repeat (8) step(0, 0, 0, 100, 100);
    repeat (6) step(0, 0, 1, 100, 100);
    // redirect with two requests in flight on a slow memory
    lat_min = 3; lat_max = 3;
    repeat (2) step(0, 0, 1, 100, 100);
    step(1, 32'h0000_0103, 1, 100, 100);
    repeat (12) step(0, 0, 1, 100, 100);
    // redirect colliding with a response and a grant
    lat_min = 1; lat_max = 1;
    repeat (3) step(0, 0, 1, 100, 100);
    step(1, 32'h0000_0200, 1, 100, 100);
    repeat (6) step(0, 0, 1, 100, 100);
    // address wrap at the top of memory
    step(1, 32'hFFFF_FFFE, 1, 100, 100);
    repeat (10) step(0, 0, 1, 100, 100);
    // back-to-back redirects
    step(1, 32'h0000_1000, 1, 100, 100);
    step(1, 32'h0000_2000, 1, 100, 100);
    repeat (8) step(0, 0, 1, 100, 100);
    // randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 5, $urandom, $urandom_range(99) < 60, 70, 70);
    // async reset mid-stream
    lat_min = 3; lat_max = 3;
    repeat (3) step(0, 0, 0, 100, 100);
    repeat (2) step(0, 0, 0, 100, 100);
    rst = 1;
    redirect_valid_in = 0; imem_gnt_in = 0; imem_rvalid_in = 0; inst_ready_in = 0;
    #1;
    check_reset_outputs("async_rst");
    pend.delete();
    dq.delete();
    mfetch = RESET_PC;
    last_pc = 0;
    last_inst = 0;
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    lat_min = 1; lat_max = 2;
    repeat (12) step(0, 0, 1, 100, 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
